// File: rtl/alu_power_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_power_ctrl
//  Purpose  : Request-side controller for the 8-bit power-gated ALU.
//             Accepts valid/ready requests, drives registered ALU operands,
//             opcode and enable, and returns the ALU result as a one-cycle
//             response pulse. Gates the ALU after a run of idle cycles and
//             sequences a fixed wake-up delay when new work arrives.
//  Ports    :
//    clk, rst             clock, asynchronous active-high reset
//    req_valid/req_ready  request handshake
//    req_a, req_b, req_op request payload (op: 00 zero, 01 add, 10 sub, 11 xor)
//    rsp_valid, rsp_data  one-cycle response pulse and captured result
//    alu_a, alu_b, alu_op registered ALU inputs
//    alu_enable           ALU enable (low = gated)
//    alu_result           combinational ALU result
//    gated                high while sleeping
//    gate_count           saturating count of sleep entries since reset
//  Revision : 1.0 - initial release
// ============================================================================
module alu_power_ctrl #(
    parameter int IDLE_LIMIT  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [1:0] req_op,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_enable,
    input  logic [7:0] alu_result,
    output logic       gated,
    output logic [7:0] gate_count
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    localparam logic [7:0] c_idle_last = 8'(IDLE_LIMIT - 1);
    localparam logic [3:0] c_wake_last = 4'(WAKE_CYCLES - 1);

    state_t     r_state,      w_state_nxt;
    logic [7:0] r_idle_cnt,   w_idle_cnt_nxt;
    logic [3:0] r_wake_cnt,   w_wake_cnt_nxt;
    logic       r_pending,    w_pending_nxt;
    logic [7:0] r_alu_a,      w_alu_a_nxt;
    logic [7:0] r_alu_b,      w_alu_b_nxt;
    logic [1:0] r_alu_op,     w_alu_op_nxt;
    logic       r_rsp_valid,  w_rsp_valid_nxt;
    logic [7:0] r_rsp_data,   w_rsp_data_nxt;
    logic [7:0] r_gate_count, w_gate_count_nxt;

    logic w_ready;
    logic w_accept;

    assign w_ready  = (r_state == ST_ACTIVE);
    assign w_accept = req_valid & w_ready;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ACTIVE;
            r_idle_cnt   <= 8'd0;
            r_wake_cnt   <= 4'd0;
            r_pending    <= 1'b0;
            r_alu_a      <= 8'd0;
            r_alu_b      <= 8'd0;
            r_alu_op     <= 2'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'd0;
            r_gate_count <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_wake_cnt   <= w_wake_cnt_nxt;
            r_pending    <= w_pending_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_gate_count <= w_gate_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_idle_cnt_nxt   = r_idle_cnt;
        w_wake_cnt_nxt   = r_wake_cnt;
        w_pending_nxt    = 1'b0;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_alu_op_nxt     = r_alu_op;
        w_gate_count_nxt = r_gate_count;
        // The response is the ALU output one edge after the operands were
        // registered; rsp_data holds between pulses.
        w_rsp_valid_nxt  = r_pending;
        w_rsp_data_nxt   = r_pending ? alu_result : r_rsp_data;

        unique case (r_state)
            ST_ACTIVE: begin
                if (w_accept) begin
                    // An accept always wins over the idle threshold.
                    w_alu_a_nxt    = req_a;
                    w_alu_b_nxt    = req_b;
                    w_alu_op_nxt   = req_op;
                    w_pending_nxt  = 1'b1;
                    w_idle_cnt_nxt = 8'd0;
                end else if (r_idle_cnt == c_idle_last) begin
                    // The response edge of the last accept counts toward the
                    // idle run, so sleep lands IDLE_LIMIT edges after it.
                    w_state_nxt    = ST_SLEEP;
                    w_idle_cnt_nxt = 8'd0;
                    w_alu_a_nxt    = 8'd0;
                    w_alu_b_nxt    = 8'd0;
                    w_alu_op_nxt   = 2'd0;
                    if (r_gate_count != 8'hFF) begin
                        w_gate_count_nxt = r_gate_count + 8'd1;
                    end
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 8'd1;
                end
            end

            ST_SLEEP: begin
                // The request only triggers the wake; it is accepted later.
                if (req_valid) begin
                    w_state_nxt    = ST_WAKE;
                    w_wake_cnt_nxt = 4'd0;
                end
            end

            ST_WAKE: begin
                if (r_wake_cnt == c_wake_last) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_idle_cnt_nxt = 8'd0;
                    w_wake_cnt_nxt = 4'd0;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready  = w_ready;
    assign alu_enable = (r_state != ST_SLEEP);
    assign gated      = (r_state == ST_SLEEP);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign gate_count = r_gate_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_power_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_power_ctrl
//  Purpose  : Self-checking bench for alu_power_ctrl. A behavioural model
//             predicts every output each cycle; directed sequences add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_power_ctrl;

    localparam int IDLE_LIMIT  = 8;
    localparam int WAKE_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_a = 8'd0;
    logic [7:0] req_b = 8'd0;
    logic [1:0] req_op = 2'd0;
    logic       req_ready, rsp_valid, alu_enable, gated;
    logic [7:0] rsp_data, alu_a, alu_b, alu_result, gate_count;
    logic [1:0] alu_op;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_power_ctrl #(
        .IDLE_LIMIT (IDLE_LIMIT),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_enable(alu_enable),
        .alu_result(alu_result),
        .gated     (gated),
        .gate_count(gate_count)
    );

    // Power-gated ALU: combinational, outputs zero when disabled.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b01:   return a + b;
            2'b10:   return a - b;
            2'b11:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction
    assign alu_result = alu_enable ? alu_f(alu_a, alu_b, alu_op) : 8'h00;

    // Expected result from plain integer arithmetic modulo 256.
    function automatic logic [7:0] model_res(input int a, input int b, input int op);
        case (op)
            1:       return 8'((a + b) % 256);
            2:       return 8'((a - b + 256) % 256);
            3:       return 8'(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: sleeping flag, remaining wake cycles, quiet-edge run
    // ------------------------------------------------------------------------
    bit         m_sleep     = 1'b0;
    int         m_wake_left = 0;
    int         m_quiet     = 0;
    bit         m_pend      = 1'b0;
    logic [7:0] m_pend_res  = 8'h00;
    bit         m_rsp_valid = 1'b0;
    logic [7:0] m_rsp_data  = 8'h00;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [1:0] m_op = 2'd0;
    int         m_gates = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sleep <= 1'b0; m_wake_left <= 0; m_quiet <= 0;
            m_pend <= 1'b0; m_pend_res <= 8'h00;
            m_rsp_valid <= 1'b0; m_rsp_data <= 8'h00;
            m_a <= 8'h00; m_b <= 8'h00; m_op <= 2'd0; m_gates <= 0;
        end else begin
            m_rsp_valid <= m_pend;
            if (m_pend) m_rsp_data <= m_pend_res;
            m_pend <= 1'b0;
            if (!m_sleep && m_wake_left == 0) begin
                if (req_valid) begin
                    m_pend     <= 1'b1;
                    m_pend_res <= model_res(int'(req_a), int'(req_b), int'(req_op));
                    m_a <= req_a; m_b <= req_b; m_op <= req_op;
                    m_quiet <= 0;
                end else if (m_quiet + 1 >= IDLE_LIMIT) begin
                    m_sleep <= 1'b1;
                    m_a <= 8'h00; m_b <= 8'h00; m_op <= 2'd0;
                    m_gates <= m_gates + 1;
                    m_quiet <= 0;
                end else begin
                    m_quiet <= m_quiet + 1;
                end
            end else if (m_sleep) begin
                if (req_valid) begin
                    m_sleep     <= 1'b0;
                    m_wake_left <= WAKE_CYCLES;
                end
            end else begin
                m_wake_left <= m_wake_left - 1;
                if (m_wake_left == 1) m_quiet <= 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout at time %0t", name, $time);
    endtask

    // Drive a request and hold it until it is accepted; returns the edge count.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, output int acc_cyc);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        acc_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            logic rdy;
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc_cyc = cyc;
                break;
            end
        end
        req_valid = 1'b0;
        if (acc_cyc < 0) timeout_fail("send_accept");
    endtask

    task automatic wait_gated();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (gated) return;
        end
        timeout_fail("wait_gated");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, rel;

        // Per-cycle model comparison.
        fork
            forever begin
                @(negedge clk);
                cmp("req_ready",  req_ready,  int'(!m_sleep && m_wake_left == 0));
                cmp("alu_enable", alu_enable, int'(!m_sleep));
                cmp("gated",      gated,      int'(m_sleep));
                cmp("rsp_valid",  rsp_valid,  int'(m_rsp_valid));
                cmp("rsp_data",   rsp_data,   m_rsp_data);
                cmp("alu_a",      alu_a,      m_a);
                cmp("alu_b",      alu_b,      m_b);
                cmp("alu_op",     alu_op,     m_op);
                cmp("gate_count", gate_count, (m_gates > 255) ? 255 : m_gates);
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_req_ready", req_ready, 1);
        cmp("rst_alu_enable", alu_enable, 1);
        cmp("rst_gated", gated, 0);
        cmp("rst_gate_count", gate_count, 0);
        cmp("rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;

        // Single add: 0F + 01
        send(8'h0F, 8'h01, 2'b01, acc);
        cmp("t1_alu_a", alu_a, 8'h0F);
        cmp("t1_alu_op", alu_op, 1);
        cmp("t1_rsp_valid_early", rsp_valid, 0);
        @(posedge clk); #1;
        cmp("t1_rsp_valid", rsp_valid, 1);
        cmp("t1_rsp_data", rsp_data, 8'h10);
        cmp("t1_alu_enable", alu_enable, 1);

        // Back-to-back sub then xor, then wrapping add
        send(8'h05, 8'h07, 2'b10, acc);
        send(8'hAA, 8'hFF, 2'b11, acc);
        cmp("t2_sub_valid", rsp_valid, 1);
        cmp("t2_sub_data", rsp_data, 8'hFE);
        @(posedge clk); #1;
        cmp("t2_xor_valid", rsp_valid, 1);
        cmp("t2_xor_data", rsp_data, 8'h55);
        send(8'hFF, 8'h02, 2'b01, acc);
        @(posedge clk); #1;
        cmp("t2_wrap_data", rsp_data, 8'h01);
        @(posedge clk); #1;
        cmp("t2_pulse_end", rsp_valid, 0);
        cmp("t2_data_hold", rsp_data, 8'h01);

        // Idle gating
        wait_gated();
        cmp("t3_gate_edges", cyc - acc, IDLE_LIMIT);
        cmp("t3_alu_enable", alu_enable, 0);
        cmp("t3_alu_a", alu_a, 0);
        cmp("t3_alu_op", alu_op, 0);
        cmp("t3_gate_count", gate_count, 1);

        // Wake: 30 - 0C = 24
        req_valid = 1'b1; req_a = 8'h30; req_b = 8'h0C; req_op = 2'b10;
        @(posedge clk); #1;
        cmp("t4_wake_ready0", req_ready, 0);
        cmp("t4_wake_enable", alu_enable, 1);
        cmp("t4_wake_gated", gated, 0);
        @(posedge clk); #1;
        cmp("t4_wake_ready1", req_ready, 0);
        @(posedge clk); #1;
        cmp("t4_active_ready", req_ready, 1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        cmp("t4_alu_a", alu_a, 8'h30);
        @(posedge clk); #1;
        cmp("t4_rsp_data", rsp_data, 8'h24);
        wait_gated();
        cmp("t4_gate_edges", cyc - acc, IDLE_LIMIT);
        cmp("t4_gate_count", gate_count, 2);

        // Threshold collision
        send(8'h01, 8'h02, 2'b01, acc);
        repeat (IDLE_LIMIT - 1) @(posedge clk);
        #1;
        send(8'h10, 8'h20, 2'b01, acc2);
        cmp("t5_collide_edge", acc2 - acc, IDLE_LIMIT);
        cmp("t5_no_gate", gated, 0);
        cmp("t5_gate_count", gate_count, 2);
        @(posedge clk); #1;
        cmp("t5_rsp_data", rsp_data, 8'h30);
        wait_gated();
        cmp("t5_gate_edges", cyc - acc2, IDLE_LIMIT);
        cmp("t5_gate_count2", gate_count, 3);

        // Asynchronous reset with a request in flight
        send(8'h11, 8'h22, 2'b01, acc);
        rst = 1'b1;
        #1;
        cmp("t6_rsp_valid", rsp_valid, 0);
        cmp("t6_rsp_data", rsp_data, 0);
        cmp("t6_req_ready", req_ready, 1);
        cmp("t6_alu_enable", alu_enable, 1);
        cmp("t6_alu_a", alu_a, 0);
        cmp("t6_gate_count", gate_count, 0);
        @(posedge clk); #1;
        cmp("t6_no_pulse", rsp_valid, 0);
        rst = 1'b0;
        rel = cyc;
        wait_gated();
        cmp("t6_reset_gate_edges", cyc - rel, IDLE_LIMIT);
        cmp("t6_gate_count1", gate_count, 1);

        // Saturation of gate_count
        for (int k = 0; k < 300; k++) begin
            send(8'h00, 8'h00, 2'b00, acc);
            wait_gated();
        end
        cmp("t6_gate_sat", gate_count, 255);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
